// File: rtl/alu_muldiv_sequencer_pkg.sv
// Shared constants, state encoding and error-outcome helpers for the
// multi-cycle MUL/DIV sequencer built around a single Hack ALU.
package alu_muldiv_sequencer_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    // Hack ALU control word, bit order {zx, nx, zy, ny, f, no}
    localparam logic [5:0] CW_ADD  = 6'b000010;
    localparam logic [5:0] CW_SUB  = 6'b010011;
    localparam logic [5:0] CW_IDLE = 6'b101010;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] remainder;
    } outcome_t;

    function automatic logic is_error_op(input logic [1:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
        logic bad;
        if (op == OP_MUL) begin
            bad = 1'b0;
        end else if (op == OP_DIV) begin
            bad = (b == '0) || a[WIDTH-1] || b[WIDTH-1];
        end else begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    // Division by zero reports all-ones quotient and passes the dividend back
    function automatic outcome_t error_outcome(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        outcome_t o;
        o.result    = '0;
        o.remainder = '0;
        if (op == OP_DIV && b == '0) begin
            o.result    = '1;
            o.remainder = a;
        end
        return o;
    endfunction

endpackage

// File: rtl/alu_muldiv_sequencer_if.sv
// START/DONE coprocessor bus between the CPU side and the MUL/DIV sequencer.
interface alu_muldiv_sequencer_if;
    import alu_muldiv_sequencer_pkg::*;

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic             zr;
    logic             ng;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, op, a, b,
        input  result, remainder, zr, ng, busy, done, err
    );

    modport slave (
        input  start, op, a, b,
        output result, remainder, zr, ng, busy, done, err
    );

endinterface

// File: rtl/alu_muldiv_sequencer_alu.sv
// Combinational Hack ALU: optional zero/negate of each input, add or AND,
// optional negate of the output.
module alu_muldiv_sequencer_alu
    import alu_muldiv_sequencer_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       cw,
    output logic [WIDTH-1:0] out,
    output logic             ng
);

    logic [WIDTH-1:0] x_z, x_n, y_z, y_n, f_out;

    assign x_z   = cw[5] ? '0 : x;
    assign x_n   = cw[4] ? ~x_z : x_z;
    assign y_z   = cw[3] ? '0 : y;
    assign y_n   = cw[2] ? ~y_z : y_z;
    assign f_out = cw[1] ? (x_n + y_n) : (x_n & y_n);
    assign out   = cw[0] ? ~f_out : f_out;
    assign ng    = out[WIDTH-1];

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Shift-add multiply and restoring divide sequenced over 16 iterations of a
// single Hack ALU; illegal requests bypass RUN and report ERR one cycle later.
module alu_muldiv_sequencer
    import alu_muldiv_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    alu_muldiv_sequencer_if.slave bus
);

    state_t state, state_next;

    logic             err_pend;
    logic [1:0]       op_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, mc, mp;
    logic [WIDTH-1:0] rem, q, d;
    logic [WIDTH-1:0] result_r, remainder_r;
    logic             zr_r, ng_r, err_r;

    logic [WIDTH-1:0] alu_x, alu_y, alu_out;
    logic [5:0]       alu_cw;
    logic             alu_ng;

    logic             accept, start_err, finish_err, last_iter, is_mul;
    logic [WIDTH-1:0] rs, acc_next, rem_next, q_next;
    logic [WIDTH-1:0] fin_res, fin_rem;
    outcome_t         err_out;

    assign is_mul     = (op_reg == OP_MUL);
    assign accept     = (state == ST_IDLE) && !err_pend && bus.start;
    assign start_err  = is_error_op(bus.op, bus.a, bus.b);
    assign finish_err = (state == ST_IDLE) && err_pend;
    assign last_iter  = (state == ST_RUN) && (cnt == CNT_W'(15));

    assign rs       = {rem[WIDTH-2:0], q[WIDTH-1]};
    assign acc_next = mp[0] ? alu_out : acc;
    assign rem_next = alu_ng ? rs : alu_out;
    assign q_next   = {q[WIDTH-2:0], ~alu_ng};
    assign fin_res  = is_mul ? acc_next : q_next;
    assign fin_rem  = is_mul ? '0 : rem_next;
    assign err_out  = error_outcome(op_reg, q, d);

    always_comb begin
        alu_x  = '0;
        alu_y  = '0;
        alu_cw = CW_IDLE;
        if (state == ST_RUN) begin
            if (is_mul) begin
                alu_x  = acc;
                alu_y  = mc;
                alu_cw = CW_ADD;
            end else begin
                alu_x  = rs;
                alu_y  = d;
                alu_cw = CW_SUB;
            end
        end
    end

    alu_muldiv_sequencer_alu u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .cw  (alu_cw),
        .out (alu_out),
        .ng  (alu_ng)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Error requests wait one cycle in IDLE (err_pend) so ERR lands with DONE
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (err_pend) begin
                    state_next = ST_DONE;
                end else if (bus.start && !start_err) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(15)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pend    <= 1'b0;
            op_reg      <= '0;
            cnt         <= '0;
            acc         <= '0;
            mc          <= '0;
            mp          <= '0;
            rem         <= '0;
            q           <= '0;
            d           <= '0;
            result_r    <= '0;
            remainder_r <= '0;
            zr_r        <= 1'b0;
            ng_r        <= 1'b0;
            err_r       <= 1'b0;
        end else if (accept) begin
            op_reg   <= bus.op;
            cnt      <= '0;
            err_r    <= 1'b0;
            err_pend <= start_err;
            acc      <= '0;
            mc       <= bus.a;
            mp       <= bus.b;
            rem      <= '0;
            q        <= bus.a;
            d        <= bus.b;
        end else if (finish_err) begin
            err_pend    <= 1'b0;
            err_r       <= 1'b1;
            result_r    <= err_out.result;
            remainder_r <= err_out.remainder;
            zr_r        <= (err_out.result == '0);
            ng_r        <= err_out.result[WIDTH-1];
        end else if (state == ST_RUN) begin
            cnt <= cnt + CNT_W'(1);
            if (is_mul) begin
                acc <= acc_next;
                mc  <= mc << 1;
                mp  <= mp >> 1;
            end else begin
                rem <= rem_next;
                q   <= q_next;
            end
            if (last_iter) begin
                result_r    <= fin_res;
                remainder_r <= fin_rem;
                zr_r        <= (fin_res == '0);
                ng_r        <= fin_res[WIDTH-1];
            end
        end
    end

    assign bus.result    = result_r;
    assign bus.remainder = remainder_r;
    assign bus.zr        = zr_r;
    assign bus.ng        = ng_r;
    assign bus.err       = err_r;
    assign bus.busy      = (state == ST_RUN);
    assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed scoreboard bench for the MUL/DIV sequencer: expectations come from
// an arithmetic model and are checked when DONE is observed.
module tb_alu_muldiv_sequencer;

    logic clk;
    logic rst_n;

    alu_muldiv_sequencer_if bus();

    alu_muldiv_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [15:0] rem;
        logic        zr;
        logic        ng;
        logic        err;
        int          lat;
        int          busy_len;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   passed;

    function automatic exp_t model(input logic [1:0] op, input logic [15:0] a,
                                   input logic [15:0] b);
        exp_t        e;
        logic [31:0] p;
        e.err = 1'b0;
        e.lat = 16;
        e.busy_len = 16;
        e.res = 16'h0;
        e.rem = 16'h0;
        if (op == 2'b00) begin
            p = 32'(a) * 32'(b);
            e.res = p[15:0];
        end else if (op == 2'b01 && b == 16'h0) begin
            e.err = 1'b1;
            e.res = 16'hFFFF;
            e.rem = a;
        end else if (op == 2'b01 && (a[15] || b[15])) begin
            e.err = 1'b1;
        end else if (op == 2'b01) begin
            e.res = a / b;
            e.rem = a % b;
        end else begin
            e.err = 1'b1;
        end
        if (e.err) begin
            e.lat = 1;
            e.busy_len = 0;
        end
        e.zr = (e.res == 16'h0);
        e.ng = e.res[15];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input bit expect_done);
        if (expect_done) sb.push_back(model(op, a, b));
        @(negedge clk);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input bit disturb);
        int          done_at;
        int          done_pulses;
        int          busy_cycles;
        logic [15:0] c_res, c_rem;
        logic        c_zr, c_ng, c_err;
        exp_t        e;
        done_at = -1;
        done_pulses = 0;
        busy_cycles = 0;
        c_res = 'x; c_rem = 'x; c_zr = 'x; c_ng = 'x; c_err = 'x;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                done_pulses++;
                if (done_at < 0) begin
                    done_at = k;
                    c_res = bus.result;
                    c_rem = bus.remainder;
                    c_zr  = bus.zr;
                    c_ng  = bus.ng;
                    c_err = bus.err;
                end
            end
            if (disturb && (k == 3 || k == 10)) begin
                bus.start = 1'b1;
                bus.a     = 16'h1234 + 16'(k);
                bus.b     = 16'h0F0F;
                bus.op    = 2'b01;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check($sformatf("%s.sb_nonempty", tag), 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s.result", tag), 32'(c_res), 32'(e.res));
            check($sformatf("%s.remainder", tag), 32'(c_rem), 32'(e.rem));
            check($sformatf("%s.zr", tag), 32'(c_zr), 32'(e.zr));
            check($sformatf("%s.ng", tag), 32'(c_ng), 32'(e.ng));
            check($sformatf("%s.err", tag), 32'(c_err), 32'(e.err));
            check($sformatf("%s.done_cycle", tag), 32'(done_at), 32'(e.lat));
            check($sformatf("%s.busy_cycles", tag), 32'(busy_cycles), 32'(e.busy_len));
            check($sformatf("%s.done_pulses", tag), 32'(done_pulses), 32'd1);
            check($sformatf("%s.held", tag), 32'(bus.result), 32'(e.res));
        end
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = 16'h0;
        bus.b = 16'h0;
        repeat (3) @(negedge clk);
        check("reset.result", 32'(bus.result), 32'h0);
        check("reset.remainder", 32'(bus.remainder), 32'h0);
        check("reset.zr", 32'(bus.zr), 32'h0);
        check("reset.ng", 32'(bus.ng), 32'h0);
        check("reset.busy", 32'(bus.busy), 32'h0);
        check("reset.done", 32'(bus.done), 32'h0);
        check("reset.err", 32'(bus.err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(2'b00, 16'd7, 16'd6, 1'b1);           checkOutput("mul_7x6", 1'b0);
        applyStimulus(2'b00, 16'h0100, 16'h0100, 1'b1);     checkOutput("mul_wrap0", 1'b0);
        applyStimulus(2'b00, 16'hFFFF, 16'd3, 1'b1);        checkOutput("mul_neg", 1'b0);
        applyStimulus(2'b01, 16'd100, 16'd7, 1'b1);         checkOutput("div_100_7", 1'b0);
        applyStimulus(2'b01, 16'h7FFF, 16'd1, 1'b1);        checkOutput("div_max_1", 1'b0);
        applyStimulus(2'b01, 16'd3, 16'd9, 1'b1);           checkOutput("div_3_9", 1'b0);
        applyStimulus(2'b01, 16'd5, 16'd0, 1'b1);           checkOutput("div_by_zero", 1'b0);
        applyStimulus(2'b01, 16'h8000, 16'd2, 1'b1);        checkOutput("div_neg_a", 1'b0);
        applyStimulus(2'b11, 16'd5, 16'd3, 1'b1);           checkOutput("op_reserved", 1'b0);
        applyStimulus(2'b10, 16'd9, 16'd4, 1'b1);           checkOutput("op_reserved2", 1'b0);

        for (int i = 0; i < 3; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom_range(0, 32'h7FFF));
            rb = 16'($urandom_range(1, 32'h7FFF));
            applyStimulus(2'b01, ra, rb, 1'b1);
            checkOutput($sformatf("div_rand%0d", i), 1'b0);
            applyStimulus(2'b00, ra, rb, 1'b1);
            checkOutput($sformatf("mul_rand%0d", i), 1'b0);
        end

        applyStimulus(2'b00, 16'd7, 16'd6, 1'b1);
        checkOutput("mul_disturbed", 1'b1);

        applyStimulus(2'b00, 16'd300, 16'd5, 1'b0);
        repeat (8) @(negedge clk);
        check("abort.busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        check("abort.result", 32'(bus.result), 32'd0);
        check("abort.err", 32'(bus.err), 32'd0);
        repeat (2) @(negedge clk);
        check("abort.no_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(2'b01, 16'd100, 16'd7, 1'b1);
        checkOutput("after_abort_div", 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
